// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
//
// Register file and ALU datapath for the simplified 8080 core. The block is
// steered entirely by the combinational control decoder upstream of it. It
// drives the internal bus from the source the decoder selects, loads the
// registers the decoder enables, and returns the instruction register and
// step counter so the decoder can compute the next step.
//
// Parameters
//   WIDTH            datapath width (default 8). IR, counter, flags and the
//                    retire counter have fixed widths.
//
// Ports
//   clk              single clock; all state changes on the rising edge
//   reset            synchronous, active-high; overrides run
//   run              step enable; 0 holds every piece of state
//   data_in          external instruction / immediate byte
//   data_in_select   bus source: data_in            (highest priority)
//   r2_select        bus source: ALU result register r2
//   const_select     bus source: constant 1
//   rX_select        bus source: register X, priority A,B,C,D,E,H,L
//   rX_enable        load register X from the bus
//   r1_enable        load ALU operand register r1 from the bus
//   r2_enable        load r2 with the ALU result and update the flags
//   rIR_enable       load the instruction register straight from data_in
//   ALU_control      0: r1 + bus, 1: bus - r1
//   counter_clear    clear the step counter (else it counts up, wrapping)
//   done             instruction-complete strobe; bumps the retire count
//   debug_sel        register view select, 8080 code (111=A, 000..101=B..L,
//                    110=r2)
//   bus              current bus value (combinational)
//   rIR_data         instruction register
//   counter          step counter
//   flags            {S, Z, CY}
//   retired          number of completed instructions, wraps at 16 bits
//   debug_data       selected register (combinational)
// -----------------------------------------------------------------------------
module cpu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_select,
  input  logic             r2_select,
  input  logic             const_select,
  input  logic             rA_select,
  input  logic             rB_select,
  input  logic             rC_select,
  input  logic             rD_select,
  input  logic             rE_select,
  input  logic             rH_select,
  input  logic             rL_select,
  input  logic             rA_enable,
  input  logic             rB_enable,
  input  logic             rC_enable,
  input  logic             rD_enable,
  input  logic             rE_enable,
  input  logic             rH_enable,
  input  logic             rL_enable,
  input  logic             r1_enable,
  input  logic             r2_enable,
  input  logic             rIR_enable,
  input  logic             ALU_control,
  input  logic             counter_clear,
  input  logic             done,
  input  logic [2:0]       debug_sel,
  output logic [WIDTH-1:0] bus,
  output logic [7:0]       rIR_data,
  output logic [1:0]       counter,
  output logic [2:0]       flags,
  output logic [15:0]      retired,
  output logic [WIDTH-1:0] debug_data
);

  // General-purpose registers live in one array; index order is also the
  // bus priority order (A highest).
  localparam int NUM_GPR = 7;
  localparam int IDX_A   = 0;
  localparam int IDX_B   = 1;
  localparam int IDX_C   = 2;
  localparam int IDX_D   = 3;
  localparam int IDX_E   = 4;
  localparam int IDX_H   = 5;
  localparam int IDX_L   = 6;

  typedef struct packed {
    logic s;
    logic z;
    logic cy;
  } flags_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] gpr_q [NUM_GPR];
  logic [WIDTH-1:0] gpr_d [NUM_GPR];
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [7:0]       rir_q, rir_d;
  logic [1:0]       counter_q, counter_d;
  flags_t           flags_q, flags_d;
  logic [15:0]      retired_q, retired_d;

  // ---------------------------------------------------------------------------
  // Select / enable vectors, packed in register-array order
  // ---------------------------------------------------------------------------
  logic [NUM_GPR-1:0] gpr_sel;
  logic [NUM_GPR-1:0] gpr_en;

  assign gpr_sel = {rL_select, rH_select, rE_select, rD_select,
                    rC_select, rB_select, rA_select};
  assign gpr_en  = {rL_enable, rH_enable, rE_enable, rD_enable,
                    rC_enable, rB_enable, rA_enable};

  // ---------------------------------------------------------------------------
  // Bus multiplexer
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] bus_w;

  // NOTE: every variable written in an always_comb block gets a default
  // first, so no path through the block can leave it unassigned and infer a
  // latch.
  always_comb begin
    bus_w = '0;
    if (data_in_select) begin
      bus_w = data_in;
    end else if (r2_select) begin
      bus_w = r2_q;
    end else if (const_select) begin
      bus_w = WIDTH'(1);
    end else begin
      // Walk from lowest to highest priority so the last hit (A) wins.
      for (int i = NUM_GPR - 1; i >= 0; i--) begin
        if (gpr_sel[i]) bus_w = gpr_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  // Both operations run one bit wider than the datapath. For the add the top
  // bit is the carry out; for the subtract it is set exactly when bus < r1,
  // which is the borrow.
  logic [WIDTH:0]   alu_wide;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  always_comb begin
    if (ALU_control) alu_wide = {1'b0, bus_w} - {1'b0, r1_q};
    else             alu_wide = {1'b0, r1_q}  + {1'b0, bus_w};
  end

  assign alu_result = alu_wide[WIDTH-1:0];
  assign alu_carry  = alu_wide[WIDTH];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Everything holds unless run is high. Register loads take the bus value of
  // the current cycle, so a register that is both selected and enabled
  // reloads its own old value.
  always_comb begin
    gpr_d     = gpr_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    rir_d     = rir_q;
    counter_d = counter_q;
    flags_d   = flags_q;
    retired_d = retired_q;

    if (run) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (gpr_en[i]) gpr_d[i] = bus_w;
      end

      if (r1_enable) r1_d = bus_w;

      if (r2_enable) begin
        r2_d       = alu_result;
        flags_d.s  = alu_result[WIDTH-1];
        flags_d.z  = (alu_result == '0);
        flags_d.cy = alu_carry;
      end

      // The IR bypasses the bus so a fetch can overlap the last step of the
      // previous instruction, which may be using the bus.
      if (rIR_enable) rir_d = 8'(data_in);

      counter_d = counter_clear ? 2'd0 : counter_q + 2'd1;

      if (done) retired_d = retired_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is part of the architectural reset state, so
      // it is cleared like any other flop here; it is a handful of registers,
      // not a RAM macro that would lack a reset.
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      rir_q     <= '0;
      counter_q <= '0;
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      gpr_q     <= gpr_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      rir_q     <= rir_d;
      counter_q <= counter_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug view, 8080 register encoding
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] debug_w;

  always_comb begin
    debug_w = '0;
    case (debug_sel)
      3'b111:  debug_w = gpr_q[IDX_A];
      3'b000:  debug_w = gpr_q[IDX_B];
      3'b001:  debug_w = gpr_q[IDX_C];
      3'b010:  debug_w = gpr_q[IDX_D];
      3'b011:  debug_w = gpr_q[IDX_E];
      3'b100:  debug_w = gpr_q[IDX_H];
      3'b101:  debug_w = gpr_q[IDX_L];
      3'b110:  debug_w = r2_q;
      default: debug_w = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus        = bus_w;
  assign rIR_data   = rir_q;
  assign counter    = counter_q;
  assign flags      = flags_q;
  assign retired    = retired_q;
  assign debug_data = debug_w;

endmodule

// File: tb/tb_cpu_datapath.sv
// -----------------------------------------------------------------------------
// tb_cpu_datapath
//
// Self-checking bench for cpu_datapath. The bench plays the role of the
// control decoder: it derives the select/enable lines for each step of an
// instruction from the opcode and step number it is issuing. A table of
// instructions with hand-derived architectural results drives the main run;
// each issued instruction pushes its expected result onto a scoreboard that
// is popped once the final step has retired. Hand-written sequences cover
// bus priority, counter wrap, stalls and a mid-instruction reset.
// -----------------------------------------------------------------------------
module tb_cpu_datapath;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, run;
  logic [WIDTH-1:0] data_in;
  logic             data_in_select, r2_select, const_select;
  logic             rA_select, rB_select, rC_select, rD_select;
  logic             rE_select, rH_select, rL_select;
  logic             rA_enable, rB_enable, rC_enable, rD_enable;
  logic             rE_enable, rH_enable, rL_enable;
  logic             r1_enable, r2_enable, rIR_enable;
  logic             ALU_control, counter_clear, done;
  logic [2:0]       debug_sel;
  logic [WIDTH-1:0] bus, debug_data;
  logic [7:0]       rIR_data;
  logic [1:0]       counter;
  logic [2:0]       flags;
  logic [15:0]      retired;

  cpu_datapath #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .run(run), .data_in(data_in),
    .data_in_select(data_in_select), .r2_select(r2_select),
    .const_select(const_select),
    .rA_select(rA_select), .rB_select(rB_select), .rC_select(rC_select),
    .rD_select(rD_select), .rE_select(rE_select), .rH_select(rH_select),
    .rL_select(rL_select),
    .rA_enable(rA_enable), .rB_enable(rB_enable), .rC_enable(rC_enable),
    .rD_enable(rD_enable), .rE_enable(rE_enable), .rH_enable(rH_enable),
    .rL_enable(rL_enable),
    .r1_enable(r1_enable), .r2_enable(r2_enable), .rIR_enable(rIR_enable),
    .ALU_control(ALU_control), .counter_clear(counter_clear), .done(done),
    .debug_sel(debug_sel), .bus(bus), .rIR_data(rIR_data),
    .counter(counter), .flags(flags), .retired(retired),
    .debug_data(debug_data)
  );

  // Control word; sel/en bit 0 = A ... bit 6 = L.
  typedef struct packed {
    logic       din_sel;
    logic       r2_sel;
    logic       const_sel;
    logic [6:0] sel;
    logic [6:0] en;
    logic       r1_en;
    logic       r2_en;
    logic       ir_en;
    logic       alu;
    logic       clr;
    logic       done;
  } ctl_t;

  typedef struct {
    bit         rst_before;
    logic [7:0] op;
    logic [7:0] imm;
    int         stall;
    logic [2:0] exp_sel;
    logic [7:0] exp_val;
    logic [2:0] exp_flags;
    logic [15:0] exp_ret;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  val;
    logic [2:0]  flg;
    logic [15:0] ret;
    logic [7:0]  next_ir;
  } exp_t;

  typedef struct {
    ctl_t       c;
    logic [7:0] exp;
  } bus_vec_t;

  exp_t       sb[$];
  logic [7:0] m_reg [8];
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input ctl_t c, input logic [7:0] din, input logic r);
    run            = r;
    data_in        = din;
    data_in_select = c.din_sel;
    r2_select      = c.r2_sel;
    const_select   = c.const_sel;
    {rL_select, rH_select, rE_select, rD_select,
     rC_select, rB_select, rA_select} = c.sel;
    {rL_enable, rH_enable, rE_enable, rD_enable,
     rC_enable, rB_enable, rA_enable} = c.en;
    r1_enable      = c.r1_en;
    r2_enable      = c.r2_en;
    rIR_enable     = c.ir_en;
    ALU_control    = c.alu;
    counter_clear  = c.clr;
    done           = c.done;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t rand_ctl();
    logic [31:0] r;
    r = $urandom;
    rand_ctl = r[$bits(ctl_t)-1:0];
  endfunction

  // 8080 register code to one-hot in A..L order.
  function automatic logic [6:0] onehot(input logic [2:0] code);
    int idx;
    idx = (code == 3'b111) ? 0 : int'(code) + 1;
    onehot = 7'b1 << idx;
  endfunction

  function automatic int nsteps(input logic [7:0] op);
    if (op[7:6] == 2'b01)                          nsteps = 1;
    else if (op[7:6] == 2'b00 && op[2:0] == 3'b110) nsteps = 2;
    else                                            nsteps = 3;
  endfunction

  // Control lines for one step (the final-step fetch bits are added by exec).
  function automatic ctl_t decode(input logic [7:0] op, input int s);
    ctl_t       c;
    logic [6:0] d, r, a;
    c = '0;
    d = onehot(op[5:3]);
    r = onehot(op[2:0]);
    a = onehot(3'b111);
    if (op[7:6] == 2'b01) begin                       // MOV d,r
      c.sel = r; c.en = d;
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'b110) begin  // MVI d
      if (s == 0) begin c.din_sel = 1'b1; c.en = d; end
    end else if (op[7:6] == 2'b00) begin              // INR / DCR d
      case (s)
        0: begin c.const_sel = 1'b1; c.r1_en = 1'b1; end
        1: begin c.sel = d; c.r2_en = 1'b1; c.alu = op[0]; end
        default: begin c.r2_sel = 1'b1; c.en = d; end
      endcase
    end else if (op[7:3] == 5'b10000) begin           // ADD r
      case (s)
        0: begin c.sel = a; c.r1_en = 1'b1; end
        1: begin c.sel = r; c.r2_en = 1'b1; end
        default: begin c.r2_sel = 1'b1; c.en = a; end
      endcase
    end else begin                                    // SUB r
      case (s)
        0: begin c.sel = r; c.r1_en = 1'b1; end
        1: begin c.sel = a; c.r2_en = 1'b1; c.alu = 1'b1; end
        default: begin c.r2_sel = 1'b1; c.en = a; end
      endcase
    end
    decode = c;
  endfunction

  task automatic do_reset();
    // Random controls with run high: reset has to win over all of them.
    apply(rand_ctl(), 8'($urandom), 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    apply('0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
  endtask

  task automatic fetch(input logic [7:0] op);
    ctl_t c;
    c       = '0;
    c.ir_en = 1'b1;
    c.clr   = 1'b1;
    apply(c, op, 1'b1);
    tick();
    check("fetch_ir", rIR_data, op);
    check("fetch_counter", counter, 0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      debug_sel = 3'(i);
      #1;
      check($sformatf("%s_reg%0d", tag, i), debug_data, 0);
    end
    check({tag, "_counter"}, counter, 0);
    check({tag, "_flags"}, flags, 0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_ir"}, rIR_data, 0);
  endtask

  // Runs one instruction whose opcode is already in IR; the final step
  // fetches next_op.
  task automatic exec(input int idx, input vec_t v, input logic [7:0] next_op);
    exp_t       e, got;
    ctl_t       c;
    logic [7:0] din;
    int         n;
    n         = nsteps(v.op);
    e.sel     = v.exp_sel;
    e.val     = v.exp_val;
    e.flg     = v.exp_flags;
    e.ret     = v.exp_ret;
    e.next_ir = next_op;
    sb.push_back(e);
    for (int s = 0; s < n; s++) begin
      check($sformatf("i%0d_step%0d_counter", idx, s), counter, s);
      if (s == n - 1) begin
        for (int k = 0; k < v.stall; k++) begin
          apply(rand_ctl(), 8'($urandom), 1'b0);
          debug_sel = v.exp_sel;
          tick();
          check($sformatf("i%0d_stall%0d_counter", idx, k), counter, s);
          check($sformatf("i%0d_stall%0d_retired", idx, k), retired,
                v.exp_ret - 16'd1);
          check($sformatf("i%0d_stall%0d_reg", idx, k), debug_data,
                m_reg[v.exp_sel]);
        end
      end
      c   = decode(v.op, s);
      din = 8'($urandom);
      if (c.din_sel) din = v.imm;
      if (s == n - 1) begin
        c.done  = 1'b1;
        c.ir_en = 1'b1;
        c.clr   = 1'b1;
        din     = next_op;
      end
      apply(c, din, 1'b1);
      tick();
    end
    apply('0, 8'h00, 1'b0);
    got       = sb.pop_front();
    debug_sel = got.sel;
    #1;
    check($sformatf("i%0d_reg", idx), debug_data, got.val);
    check($sformatf("i%0d_flags", idx), flags, got.flg);
    check($sformatf("i%0d_retired", idx), retired, got.ret);
    check($sformatf("i%0d_counter", idx), counter, 0);
    check($sformatf("i%0d_ir", idx), rIR_data, got.next_ir);
    m_reg[got.sel] = got.val;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t     prog [16];
    bus_vec_t bv   [10];
    vec_t     dcr_e;
    ctl_t     c;

    //          rst  op     imm    stl sel     val    flags   ret
    prog[0]  = '{1'b1, 8'h06, 8'h2A, 0, 3'b000, 8'h2A, 3'b000, 16'd1};  // MVI B
    prog[1]  = '{1'b1, 8'h3E, 8'hFF, 0, 3'b111, 8'hFF, 3'b000, 16'd1};  // MVI A
    prog[2]  = '{1'b0, 8'h06, 8'h01, 0, 3'b000, 8'h01, 3'b000, 16'd2};  // MVI B
    prog[3]  = '{1'b0, 8'h80, 8'h00, 0, 3'b111, 8'h00, 3'b011, 16'd3};  // ADD B
    prog[4]  = '{1'b0, 8'h3E, 8'h05, 0, 3'b111, 8'h05, 3'b011, 16'd4};  // MVI A
    prog[5]  = '{1'b0, 8'h0E, 8'h07, 0, 3'b001, 8'h07, 3'b011, 16'd5};  // MVI C
    prog[6]  = '{1'b0, 8'h91, 8'h00, 0, 3'b111, 8'hFE, 3'b101, 16'd6};  // SUB C
    prog[7]  = '{1'b0, 8'h2E, 8'h00, 0, 3'b101, 8'h00, 3'b101, 16'd7};  // MVI L
    prog[8]  = '{1'b0, 8'h2D, 8'h00, 0, 3'b101, 8'hFF, 3'b101, 16'd8};  // DCR L
    prog[9]  = '{1'b0, 8'h2C, 8'h00, 0, 3'b101, 8'h00, 3'b011, 16'd9};  // INR L
    prog[10] = '{1'b0, 8'h3E, 8'h3C, 0, 3'b111, 8'h3C, 3'b011, 16'd10}; // MVI A
    prog[11] = '{1'b0, 8'h57, 8'h00, 3, 3'b010, 8'h3C, 3'b011, 16'd11}; // MOV D,A
    prog[12] = '{1'b0, 8'h3C, 8'h00, 0, 3'b111, 8'h3D, 3'b000, 16'd12}; // INR A
    prog[13] = '{1'b0, 8'h87, 8'h00, 2, 3'b111, 8'h7A, 3'b000, 16'd13}; // ADD A
    prog[14] = '{1'b0, 8'h60, 8'h00, 0, 3'b100, 8'h01, 3'b000, 16'd14}; // MOV H,B
    prog[15] = '{1'b0, 8'h90, 8'h00, 0, 3'b111, 8'h79, 3'b000, 16'd15}; // SUB B

    reset     = 1'b0;
    debug_sel = 3'b000;
    apply('0, 8'h00, 1'b0);

    // Reset state.
    do_reset();
    #1;
    check("reset_bus_idle", bus, 0);
    check_all_zero("reset");

    // Table-driven instruction run.
    for (int i = 0; i < 16; i++) begin
      if (prog[i].rst_before) begin
        do_reset();
        fetch(prog[i].op);
      end
      exec(i, prog[i], (i < 15) ? prog[i + 1].op : 8'h00);
    end

    // Bus priority. State now: A=79 B=01 C=07 D=3C E=00 H=01 L=00 r2=79.
    for (int i = 0; i < 10; i++) bv[i].c = '0;
    bv[0].c.din_sel = 1'b1; bv[0].c.r2_sel = 1'b1; bv[0].c.const_sel = 1'b1;
    bv[0].c.sel = 7'b1111111;                    bv[0].exp = 8'hC3;
    bv[1].c.r2_sel = 1'b1; bv[1].c.const_sel = 1'b1;
    bv[1].c.sel = 7'b0000001;                    bv[1].exp = 8'h79;
    bv[2].c.const_sel = 1'b1; bv[2].c.sel = 7'b0000011; bv[2].exp = 8'h01;
    bv[3].c.sel = 7'b1111111;                    bv[3].exp = 8'h79;
    bv[4].c.sel = 7'b0001110;                    bv[4].exp = 8'h01;
    bv[5].c.sel = 7'b0001100;                    bv[5].exp = 8'h07;
    bv[6].c.sel = 7'b0011000;                    bv[6].exp = 8'h3C;
    bv[7].c.sel = 7'b1110000;                    bv[7].exp = 8'h00;
    bv[8].c.sel = 7'b1100000;                    bv[8].exp = 8'h01;
    bv[9].exp = 8'h00;
    for (int i = 0; i < 10; i++) begin
      apply(bv[i].c, 8'hC3, 1'b0);
      #1;
      check($sformatf("bus_prio%0d", i), bus, bv[i].exp);
    end
    debug_sel = 3'b110;
    #1;
    check("debug_r2", debug_data, 8'h79);

    // Counter counts up and wraps when not cleared.
    for (int i = 1; i <= 4; i++) begin
      apply('0, 8'h00, 1'b1);
      tick();
      check($sformatf("counter_wrap%0d", i), counter, i % 4);
    end
    apply('0, 8'h00, 1'b0);
    check("counter_wrap_retired", retired, 16'd15);

    // DCR E (E=00 -> FF), fetching ADD E for the mid-instruction reset.
    dcr_e = '{1'b0, 8'h1D, 8'h00, 0, 3'b011, 8'hFF, 3'b101, 16'd16};
    exec(16, dcr_e, 8'h83);

    // ADD E steps 0 and 1: r2 = 79 + FF = 78 with carry.
    for (int s = 0; s < 2; s++) begin
      c = decode(8'h83, s);
      apply(c, 8'($urandom), 1'b1);
      tick();
    end
    apply('0, 8'h00, 1'b0);
    #1;
    check("midrst_counter_before", counter, 2);
    check("midrst_flags_before", flags, 3'b001);
    do_reset();
    check_all_zero("midrst");
    fetch(8'h06);

    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
